// File: rtl/control_sequencer_if.sv
// Signal bundle between the instruction sequencer and its decoder/RAM/debug environment.
// master is the sequencer side; slave is the environment driving RAM data and decoder feedback.
interface control_sequencer_if #(
    parameter int INSTR_W = 16,
    parameter int COUNT_W = 16
);
    logic [INSTR_W-1:0] ram_q;
    logic               sm_extra;
    logic               stop;
    logic               run;
    logic               step;
    logic               resume;
    logic [INSTR_W-1:0] instruction;
    logic [1:0]         state;
    logic               halted;
    logic               paused;
    logic [COUNT_W-1:0] instr_count;

    modport master (
        input  ram_q, sm_extra, stop, run, step, resume,
        output instruction, state, halted, paused, instr_count
    );

    modport slave (
        output ram_q, sm_extra, stop, run, step, resume,
        input  instruction, state, halted, paused, instr_count
    );
endinterface

// File: rtl/control_sequencer.sv
// Instruction-cycle sequencer: FETCH/EXEC1/EXEC2/IDLE cycle state, instruction register,
// halt/pause/single-step control and a retired-instruction counter. All outputs registered.
module control_sequencer #(
    parameter int INSTR_W = 16,
    parameter int COUNT_W = 16
) (
    input logic                 clock,
    input logic                 reset,
    control_sequencer_if.master bus
);
    // Encoding is dictated by the decoder; IDLE matches none of its phase decodes.
    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC1 = 2'b10,
        EXEC2 = 2'b01,
        IDLE  = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               halted_q, halted_d;
    logic               paused_q, paused_d;
    logic               pending_q, pending_d;
    logic               go;
    logic               retire;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= FETCH;
            instr_q   <= '0;
            count_q   <= '0;
            halted_q  <= 1'b0;
            paused_q  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            count_q   <= count_d;
            halted_q  <= halted_d;
            paused_q  <= paused_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        count_d   = count_q;
        halted_d  = halted_q;
        paused_d  = paused_q;
        pending_d = pending_q;
        retire    = 1'b0;
        go        = bus.run | pending_q;

        unique case (state_q)
            FETCH: begin
                if (bus.stop) begin
                    state_d  = IDLE;
                    halted_d = 1'b1;
                end else begin
                    state_d   = EXEC1;
                    instr_d   = bus.ram_q;
                    pending_d = 1'b0;
                end
            end
            EXEC1: begin
                if (bus.stop) begin
                    state_d  = IDLE;
                    halted_d = 1'b1;
                end else if (bus.sm_extra) begin
                    state_d = EXEC2;
                end else begin
                    retire = 1'b1;
                end
            end
            EXEC2: begin
                if (bus.stop) begin
                    state_d  = IDLE;
                    halted_d = 1'b1;
                end else begin
                    retire = 1'b1;
                end
            end
            IDLE: begin
                if (halted_q) begin
                    if (bus.resume) begin
                        state_d   = FETCH;
                        halted_d  = 1'b0;
                        pending_d = 1'b0;
                    end
                end else if (go) begin
                    state_d   = FETCH;
                    paused_d  = 1'b0;
                    pending_d = 1'b0;
                end
            end
            default: state_d = FETCH;
        endcase

        if (retire) begin
            count_d = count_q + 1'b1;
            if (go) begin
                state_d = FETCH;
            end else begin
                state_d  = IDLE;
                paused_d = 1'b1;
            end
        end

        // A step arriving mid-instruction is kept for the next one, so set wins over clear.
        if (bus.step && !bus.run && !halted_q) begin
            pending_d = 1'b1;
        end
    end

    assign bus.instruction = instr_q;
    assign bus.state       = state_q;
    assign bus.halted      = halted_q;
    assign bus.paused      = paused_q;
    assign bus.instr_count = count_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios with literal expectations, then random
// stimulus checked every cycle against an instruction-level reference model.
module tb_control_sequencer;
    localparam int INSTR_W = 16;
    localparam int COUNT_W = 4;
    localparam int CMOD    = 1 << COUNT_W;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    control_sequencer_if #(.INSTR_W(INSTR_W), .COUNT_W(COUNT_W)) bus ();

    control_sequencer #(.INSTR_W(INSTR_W), .COUNT_W(COUNT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Reference model: an instruction is "busy" for idx 0..len-1; outside it the block is idle.
    logic        m_busy, m_halt, m_pause, m_pend, m_valid;
    int          m_idx;
    int          m_cnt;
    logic [15:0] m_instr;

    initial begin
        m_valid = 1'b0;
        m_busy = 1'b1; m_halt = 1'b0; m_pause = 1'b0; m_pend = 1'b0;
        m_idx = 0; m_cnt = 0; m_instr = '0;
    end

    always @(posedge clock) begin : model
        logic        n_busy, n_halt, n_pause, n_pend, go;
        int          n_idx, n_cnt;
        logic [15:0] n_instr;
        n_busy = m_busy; n_halt = m_halt; n_pause = m_pause; n_pend = m_pend;
        n_idx = m_idx; n_cnt = m_cnt; n_instr = m_instr;
        if (reset) begin
            n_busy = 1'b1; n_idx = 0; n_halt = 1'b0; n_pause = 1'b0;
            n_pend = 1'b0; n_instr = '0; n_cnt = 0;
            m_valid <= 1'b1;
        end else begin
            go = bus.run | m_pend;
            if (m_busy) begin
                if (bus.stop) begin
                    n_busy = 1'b0; n_halt = 1'b1;
                end else if (m_idx == 0) begin
                    n_instr = bus.ram_q; n_idx = 1; n_pend = 1'b0;
                end else if (m_idx == 1 && bus.sm_extra) begin
                    n_idx = 2;
                end else begin
                    n_cnt = (m_cnt + 1) % CMOD;
                    if (go) n_idx = 0;
                    else begin n_busy = 1'b0; n_pause = 1'b1; end
                end
            end else if (m_halt) begin
                if (bus.resume) begin
                    n_halt = 1'b0; n_busy = 1'b1; n_idx = 0; n_pend = 1'b0;
                end
            end else if (go) begin
                n_busy = 1'b1; n_idx = 0; n_pause = 1'b0; n_pend = 1'b0;
            end
            if (bus.step && !bus.run && !m_halt) n_pend = 1'b1;
        end
        m_busy <= n_busy; m_halt <= n_halt; m_pause <= n_pause; m_pend <= n_pend;
        m_idx <= n_idx; m_cnt <= n_cnt; m_instr <= n_instr;
    end

    function automatic logic [1:0] model_state();
        if (!m_busy) return 2'b11;
        case (m_idx)
            0:       return 2'b00;
            1:       return 2'b10;
            default: return 2'b01;
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (m_valid) begin
            check("state",       int'(bus.state),       int'(model_state()));
            check("instruction", int'(bus.instruction), int'(m_instr));
            check("halted",      int'(bus.halted),      int'(m_halt));
            check("paused",      int'(bus.paused),      int'(m_pause));
            check("instr_count", int'(bus.instr_count), m_cnt);
            check("halt_pause_excl", int'(bus.halted & bus.paused), 0);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_out(input string tag, input logic [1:0] st, input int cnt);
        check({tag, "_state"}, int'(bus.state), int'(st));
        check({tag, "_count"}, int'(bus.instr_count), cnt);
    endtask

    initial begin
        reset = 1'b1;
        bus.ram_q = 16'h4401; bus.sm_extra = 1'b0; bus.stop = 1'b0;
        bus.run = 1'b1; bus.step = 1'b0; bus.resume = 1'b0;
        tick();
        reset = 1'b0;
        // Reset values and free-run with two-cycle instructions
        expect_out("rst", 2'b00, 0);
        check("rst_instr", int'(bus.instruction), 0);
        check("rst_halted", int'(bus.halted), 0);
        check("rst_paused", int'(bus.paused), 0);
        tick(); expect_out("t1a", 2'b10, 0);
        check("t1_instr", int'(bus.instruction), 16'h4401);
        tick(); expect_out("t1b", 2'b00, 1);
        tick(); expect_out("t1c", 2'b10, 1);
        tick(); expect_out("t1d", 2'b00, 2);
        // sm_extra stretches to EXEC2
        bus.sm_extra = 1'b1;
        tick(); expect_out("t2a", 2'b10, 2);
        tick(); expect_out("t2b", 2'b01, 2);
        bus.sm_extra = 1'b0;
        tick(); expect_out("t2c", 2'b00, 3);
        // stop in EXEC1 beats sm_extra
        tick(); expect_out("t3a", 2'b10, 3);
        bus.stop = 1'b1; bus.sm_extra = 1'b1;
        tick(); expect_out("t3b", 2'b11, 3);
        check("t3_halted", int'(bus.halted), 1);
        bus.stop = 1'b0; bus.sm_extra = 1'b0;
        tick(5); expect_out("t3c", 2'b11, 3);
        bus.run = 1'b0; bus.step = 1'b1;
        tick(); bus.step = 1'b0;
        tick(); expect_out("t6_halt_step", 2'b11, 3);
        bus.resume = 1'b1;
        tick(); bus.resume = 1'b0;
        expect_out("t3d", 2'b00, 3);
        check("t3_unhalt", int'(bus.halted), 0);
        tick(); expect_out("t4a", 2'b10, 3);
        tick(); expect_out("t4b", 2'b11, 4);
        check("t4_paused", int'(bus.paused), 1);
        // single step
        bus.step = 1'b1;
        tick(); bus.step = 1'b0;
        expect_out("t4c", 2'b11, 4);
        tick(); expect_out("t4d", 2'b00, 4);
        check("t4_unpaused", int'(bus.paused), 0);
        tick(); expect_out("t4e", 2'b10, 4);
        tick(); expect_out("t4f", 2'b11, 5);
        tick(); expect_out("t4g", 2'b11, 5);
        // step during run=1 is ignored
        bus.run = 1'b1; bus.step = 1'b1;
        tick(); bus.step = 1'b0; bus.run = 1'b0;
        expect_out("t6a", 2'b00, 5);
        tick(); expect_out("t6b", 2'b10, 5);
        tick(); expect_out("t6c", 2'b11, 6);
        // counter wrap
        bus.run = 1'b1;
        tick(19); expect_out("t5a", 2'b00, 15);
        tick(); expect_out("t5b", 2'b10, 15);
        tick(); expect_out("t5c", 2'b00, 0);
        check("model_wrap", m_cnt, 0);
        // reset in EXEC2 together with resume
        bus.ram_q = 16'hBEEF; bus.sm_extra = 1'b1;
        tick(); tick(); expect_out("t5d", 2'b01, 0);
        check("model_exec2", int'(model_state()), 2'b01);
        reset = 1'b1; bus.resume = 1'b1;
        tick(); reset = 1'b0; bus.resume = 1'b0; bus.sm_extra = 1'b0;
        expect_out("t5e", 2'b00, 0);
        check("t5_instr", int'(bus.instruction), 0);
        check("t5_halted", int'(bus.halted), 0);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            bus.ram_q    = 16'($urandom);
            bus.sm_extra = 1'($urandom_range(0, 1));
            bus.stop     = ($urandom_range(0, 29) == 0);
            bus.run      = ($urandom_range(0, 3) != 0) ^ (((i / 200) % 2) == 1);
            bus.step     = ($urandom_range(0, 5) == 0);
            bus.resume   = ($urandom_range(0, 7) == 0);
            reset        = ($urandom_range(0, 249) == 0);
            tick();
        end
        reset = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
